// File: rtl/srt_quotient_assembler.sv
// On-the-fly quotient converter for a radix-4 SRT divider: folds signed digits
// into Q/QM without a carry-propagate add, then applies remainder-sign correction.
module srt_quotient_assembler #(
    parameter int QW = 24,
    localparam int NDIGITS = QW / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          digit_valid,
    output logic          digit_ready,
    input  logic [2:0]    digit,
    input  logic          rem_valid,
    input  logic          rem_negative,
    output logic [QW-1:0] quotient,
    output logic          quotient_valid,
    input  logic          quotient_ready,
    output logic          busy,
    output logic          digit_error
);

    localparam int CW = $clog2(NDIGITS) + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCUM    = 2'd1;
    localparam logic [1:0] S_WAIT_REM = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]    state;
    logic [QW-1:0] q_r;
    logic [QW-1:0] qm_r;
    logic [CW-1:0] count;

    logic [2:0]    d_eff;
    logic [1:0]    lo_m1;
    logic [1:0]    lo_p3;
    logic          d_neg;
    logic          d_pos;
    logic [QW-1:0] q_next;
    logic [QW-1:0] qm_next;
    logic          transfer;

    assign digit_ready = (state == S_ACCUM);
    assign busy        = (state != S_IDLE);
    assign transfer    = digit_valid && digit_ready;

    // Illegal -4 is folded to zero so the Q/QM pair stays consistent.
    always_comb begin
        d_eff   = (digit == 3'b100) ? 3'b000 : digit;
        d_neg   = d_eff[2];
        d_pos   = !d_eff[2] && (d_eff != 3'b000);
        lo_m1   = d_eff[1:0] - 2'd1;
        lo_p3   = d_eff[1:0] + 2'd3;
        q_next  = d_neg ? {qm_r[QW-3:0], d_eff[1:0]} : {q_r[QW-3:0], d_eff[1:0]};
        qm_next = d_pos ? {q_r[QW-3:0], lo_m1} : {qm_r[QW-3:0], lo_p3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            q_r            <= '0;
            qm_r           <= '0;
            count          <= '0;
            quotient       <= '0;
            quotient_valid <= 1'b0;
            digit_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_r         <= '0;
                        qm_r        <= '1;
                        count       <= '0;
                        digit_error <= 1'b0;
                        state       <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (transfer) begin
                        q_r   <= q_next;
                        qm_r  <= qm_next;
                        count <= count + 1'b1;
                        if (digit == 3'b100) digit_error <= 1'b1;
                        if (count == CW'(NDIGITS - 1)) state <= S_WAIT_REM;
                    end
                end
                S_WAIT_REM: begin
                    if (rem_valid) begin
                        quotient       <= rem_negative ? qm_r : q_r;
                        quotient_valid <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                default: begin
                    if (quotient_ready) begin
                        quotient_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
